// File: rtl/iter_unsigned_div.sv
// Restoring unsigned divider: accepts dividend and divisor on independent valid/ready channels
// and produces one quotient bit per cycle. Result {q, r} is a one-cycle pulse DIV_W+1 cycles after the last operand.
module iter_unsigned_div #(
  parameter int DIV_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIV_W-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [DIV_W-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*DIV_W-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);
  localparam int CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic                 got_dvd_q, got_dvs_q;
  logic                 got_dvd_d, got_dvs_d;
  logic [DIV_W-1:0]     dvd_q, dvd_d;
  logic [DIV_W-1:0]     dvs_q, dvs_d;
  logic [DIV_W-1:0]     quo_q, quo_d;
  logic [DIV_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 tvalid_q;
  logic [2*DIV_W-1:0]   tdata_q;

  logic                 dvd_hs, dvs_hs;
  logic [DIV_W:0]       shifted;
  logic                 fits;

  assign s_axis_dividend_tready = (state_q == IDLE) && !got_dvd_q;
  assign s_axis_divisor_tready  = (state_q == IDLE) && !got_dvs_q;
  assign dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_hs = s_axis_divisor_tvalid && s_axis_divisor_tready;

  assign m_axis_dout_tvalid = tvalid_q;
  assign m_axis_dout_tdata  = tdata_q;

  always_comb begin
    got_dvd_d = got_dvd_q | dvd_hs;
    got_dvs_d = got_dvs_q | dvs_hs;
    dvd_d     = dvd_hs ? s_axis_dividend_tdata : dvd_q;
    dvs_d     = dvs_hs ? s_axis_divisor_tdata : dvs_q;
  end

  // The partial remainder stays below the divisor, so W bits hold it and the difference fits in W bits.
  always_comb begin
    shifted = {rem_q, quo_q[DIV_W-1]};
    fits    = shifted >= {1'b0, dvs_q};
    rem_d   = fits ? (shifted[DIV_W-1:0] - dvs_q) : shifted[DIV_W-1:0];
    quo_d   = {quo_q[DIV_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      got_dvd_q <= 1'b0;
      got_dvs_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dvd_q     <= dvd_d;
          dvs_q     <= dvs_d;
          got_dvd_q <= got_dvd_d;
          got_dvs_q <= got_dvs_d;
          if (got_dvd_d && got_dvs_d) begin
            state_q <= BUSY;
            rem_q   <= '0;
            quo_q   <= dvd_d;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_W - 1)) begin
            state_q  <= DONE;
            tvalid_q <= 1'b1;
            tdata_q  <= {quo_d, rem_d};
          end
        end
        DONE: begin
          tvalid_q  <= 1'b0;
          got_dvd_q <= 1'b0;
          got_dvs_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_unsigned_div.sv
// Directed table plus corner sequences for iter_unsigned_div; inputs driven and outputs sampled on negedge.
module tb_iter_unsigned_div;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_dat, b_dat;
  logic        a_vld, b_vld;
  logic        dvd_rdy, dvs_rdy;
  logic [63:0] dout_dat;
  logic        dout_vld;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          da;
    int          db;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vt[11];

  iter_unsigned_div #(.DIV_W(32)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_dividend_tdata  (a_dat),
    .s_axis_dividend_tvalid (a_vld),
    .s_axis_dividend_tready (dvd_rdy),
    .s_axis_divisor_tdata   (b_dat),
    .s_axis_divisor_tvalid  (b_vld),
    .s_axis_divisor_tready  (dvs_rdy),
    .m_axis_dout_tdata      (dout_dat),
    .m_axis_dout_tvalid     (dout_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the result pulse.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input int da, input int db, input logic [31:0] eq, input logic [31:0] er);
    int  cyc;
    int  n;
    bit  ga, gb, hsa, hsb, rdy_bad;
    cyc = 0; ga = 0; gb = 0;
    while (!(ga && gb) && cyc < 200) begin
      a_vld = (cyc >= da) && !ga;
      b_vld = (cyc >= db) && !gb;
      a_dat = a;
      b_dat = b;
      if (ga && !gb) chk({nm, "_dvd_rdy_held_low"}, {63'd0, dvd_rdy}, 64'd0);
      if (gb && !ga) chk({nm, "_dvs_rdy_held_low"}, {63'd0, dvs_rdy}, 64'd0);
      hsa = a_vld && dvd_rdy;
      hsb = b_vld && dvs_rdy;
      @(posedge clk);
      ga = ga || hsa;
      gb = gb || hsb;
      @(negedge clk);
      cyc++;
    end
    a_vld = 1'b0;
    b_vld = 1'b0;
    chk({nm, "_accepted"}, {62'd0, ga, gb}, 64'd3);
    n = 1; rdy_bad = 0;
    while (!dout_vld && n < 100) begin
      if (dvd_rdy || dvs_rdy) rdy_bad = 1;
      @(negedge clk);
      n++;
    end
    if (dvd_rdy || dvs_rdy) rdy_bad = 1;
    chk({nm, "_latency"}, 64'(n), 64'd33);
    chk({nm, "_data"}, dout_dat, {eq, er});
    chk({nm, "_rdy_low_busy"}, {63'd0, rdy_bad}, 64'd0);
    @(negedge clk);
    chk({nm, "_pulse_one_cycle"}, {63'd0, dout_vld}, 64'd0);
    chk({nm, "_hold_data"}, dout_dat, {eq, er});
    chk({nm, "_rdy_back"}, {62'd0, dvd_rdy, dvs_rdy}, 64'd3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int          pulses, hs_a, hs_b, last_pulse, seen_prev;
    bit          spacing_bad, data_bad;
    logic [31:0] ra, rb;

    vt[0]  = '{32'd100,        32'd7,          0, 0, 32'd14,         32'd2};
    vt[1]  = '{32'hFFFFFFFF,   32'h00000010,   0, 5, 32'h0FFFFFFF,   32'h0000000F};
    vt[2]  = '{32'h00001234,   32'd0,          0, 0, 32'hFFFFFFFF,   32'h00001234};
    vt[3]  = '{32'd5,          32'd9,          2, 0, 32'd0,          32'd5};
    vt[4]  = '{32'hDEADBEEF,   32'd1,          0, 1, 32'hDEADBEEF,   32'd0};
    vt[5]  = '{32'd0,          32'd5,          0, 0, 32'd0,          32'd0};
    vt[6]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1, 1, 32'd1,          32'd0};
    vt[7]  = '{32'h80000000,   32'hFFFFFFFF,   0, 0, 32'd0,          32'h80000000};
    vt[8]  = '{32'hFFFFFFFE,   32'd2,          3, 0, 32'h7FFFFFFF,   32'd0};
    vt[9]  = '{32'd12345678,   32'd1000,       0, 0, 32'd12345,      32'd678};
    vt[10] = '{32'd1000,       32'd3,          0, 0, 32'd333,        32'd1};

    a_vld = 0; b_vld = 0; a_dat = 0; b_dat = 0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_tvalid", {63'd0, dout_vld}, 64'd0);
    chk("reset_tdata", dout_dat, 64'd0);
    chk("reset_treadys", {62'd0, dvd_rdy, dvs_rdy}, 64'd3);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].da, vt[i].db, vt[i].q, vt[i].r);

    // Both producers hold valid continuously.
    pulses = 0; hs_a = 0; hs_b = 0; last_pulse = 0; seen_prev = 0;
    spacing_bad = 0; data_bad = 0;
    a_dat = 32'd1000; b_dat = 32'd3; a_vld = 1; b_vld = 1;
    for (int c = 0; c < 180; c++) begin
      if (dvd_rdy) hs_a++;
      if (dvs_rdy) hs_b++;
      if (dout_vld) begin
        if (seen_prev != 0) spacing_bad = 1;
        if (pulses > 0 && c - last_pulse != 34) spacing_bad = 1;
        if (dout_dat !== {32'd333, 32'd1}) data_bad = 1;
        pulses++;
        last_pulse = c;
      end
      seen_prev = dout_vld ? 1 : 0;
      @(negedge clk);
    end
    a_vld = 0; b_vld = 0;
    chk("b2b_pulse_count", 64'(pulses), 64'd5);
    chk("b2b_spacing", {63'd0, spacing_bad}, 64'd0);
    chk("b2b_data", {63'd0, data_bad}, 64'd0);
    chk("b2b_dvd_captures", 64'(hs_a), 64'd6);
    chk("b2b_dvs_captures", 64'(hs_b), 64'd6);
    do_reset();

    // Reset in the middle of BUSY aborts the operation.
    a_dat = 32'd100; b_dat = 32'd7; a_vld = 1; b_vld = 1;
    @(negedge clk);
    a_vld = 0; b_vld = 0;
    repeat (9) @(negedge clk);
    chk("abort_busy_rdy", {62'd0, dvd_rdy, dvs_rdy}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_treadys", {62'd0, dvd_rdy, dvs_rdy}, 64'd3);
    chk("abort_tdata", dout_dat, 64'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (dout_vld) pulses++;
      @(negedge clk);
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    run_op("after_abort", 32'd42, 32'd5, 0, 0, 32'd8, 32'd2);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom();
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom();
      if (rb == 0) rb = 32'd1;
      run_op($sformatf("rnd%0d", i), ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), ra / rb, ra % rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
